// File: rtl/aes_gcm_pkg.sv
// Shared types and helpers for the AES-GCM feed stage.
package aes_gcm_pkg;

  localparam int          AES_KS_W  = 1408;
  localparam logic [31:0] J0_SUFFIX = 32'h0000_0001;

  typedef enum logic [2:0] {
    PH_NONE = 3'd0,
    PH_AAD  = 3'd1,
    PH_PT   = 3'd2,
    PH_LEN  = 3'd3
  } phase_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_AAD  = 2'd1,
    ST_PT   = 2'd2,
    ST_LEN  = 2'd3
  } feed_state_e;

  // GCM counter increment: only the low 32-bit word wraps, the IV part is untouched.
  function automatic logic [0:127] fn_inc32(input logic [0:127] cb);
    fn_inc32 = {cb[0:95], cb[96:127] + 32'd1};
  endfunction

endpackage

// File: rtl/aes_pipeline_stage0_feed.sv
// Head of the AES-GCM encrypt pipeline: turns a descriptor plus a stream of AAD/PT
// blocks into registered pipeline beats (one per block, then one length beat).
// Optional feature macro: AES_GCM_FEED_BACK2BACK_EN (descriptor also accepted in LEN).
//
// Handshake: a transfer happens on a rising edge where valid && ready; ready is decoded
// from the state register only and never depends on the matching valid.
module aes_pipeline_stage0_feed
  import aes_gcm_pkg::*;
#(
  parameter int LEN_W = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_desc_valid,
  output logic                o_desc_ready,
  input  logic [0:95]         i_iv,
  input  logic [0:AES_KS_W-1] i_key_schedule,
  input  logic [LEN_W-1:0]    i_aad_len,
  input  logic [LEN_W-1:0]    i_pt_len,
  input  logic                i_data_valid,
  output logic                o_data_ready,
  input  logic [0:127]        i_data,
  output logic [2:0]          o_phase,
  output logic                o_new_instance,
  output logic [0:127]        o_h,
  output logic [0:127]        o_j0,
  output logic [0:127]        o_cb,
  output logic [0:127]        o_aad,
  output logic [0:127]        o_plain_text,
  output logic [0:127]        o_instance_size,
  output logic [0:AES_KS_W-1] o_key_schedule
);

  localparam int CNT_W = LEN_W - 3;
  localparam int PAD_W = 64 - LEN_W - 3;

  feed_state_e r_state;
  feed_state_e w_state_nxt;
  feed_state_e w_first_state;

  logic [0:95]         r_iv;
  logic [0:AES_KS_W-1] r_key;
  logic [LEN_W-1:0]    r_aad_len;
  logic [LEN_W-1:0]    r_pt_len;
  logic [CNT_W-1:0]    r_naad;
  logic [CNT_W-1:0]    r_npt;
  logic [0:127]        r_cb;
  logic                r_pending_new;

  logic [LEN_W:0]      w_aad_sum;
  logic [LEN_W:0]      w_pt_sum;
  logic [CNT_W-1:0]    w_naad_calc;
  logic [CNT_W-1:0]    w_npt_calc;
  logic [0:127]        w_cb_inc;
  logic [0:127]        w_size;
  logic                w_desc_acc;
  logic                w_data_acc;
  phase_e              w_phase;

  // Block counts are ceil(len/16); one extra bit keeps the +15 from overflowing.
  assign w_aad_sum   = {1'b0, i_aad_len} + (LEN_W+1)'(15);
  assign w_pt_sum    = {1'b0, i_pt_len} + (LEN_W+1)'(15);
  assign w_naad_calc = w_aad_sum[LEN_W:4];
  assign w_npt_calc  = w_pt_sum[LEN_W:4];

  assign w_first_state = (w_naad_calc != '0) ? ST_AAD :
                         (w_npt_calc != '0)  ? ST_PT  : ST_LEN;

  assign w_cb_inc = fn_inc32(r_cb);
  assign w_size   = {{PAD_W{1'b0}}, r_aad_len, 3'b000, {PAD_W{1'b0}}, r_pt_len, 3'b000};

  // H is always derived from encrypting the all-zero block.
  assign o_h = '0;

`ifdef AES_GCM_FEED_BACK2BACK_EN
  assign o_desc_ready = (r_state == ST_IDLE) || (r_state == ST_LEN);
`else
  assign o_desc_ready = (r_state == ST_IDLE);
`endif
  assign o_data_ready = (r_state == ST_AAD) || (r_state == ST_PT);

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next state, accept strobes and the phase of the beat issued this cycle.
  always_comb begin
    w_state_nxt = r_state;
    w_desc_acc  = 1'b0;
    w_data_acc  = 1'b0;
    w_phase     = PH_NONE;
    case (r_state)
      ST_IDLE: begin
        if (i_desc_valid) begin
          w_desc_acc  = 1'b1;
          w_state_nxt = w_first_state;
        end
      end
      ST_AAD: begin
        if (i_data_valid) begin
          w_data_acc = 1'b1;
          w_phase    = PH_AAD;
          if (r_naad == CNT_W'(1)) w_state_nxt = (r_npt != '0) ? ST_PT : ST_LEN;
        end
      end
      ST_PT: begin
        if (i_data_valid) begin
          w_data_acc = 1'b1;
          w_phase    = PH_PT;
          if (r_npt == CNT_W'(1)) w_state_nxt = ST_LEN;
        end
      end
      ST_LEN: begin
        w_phase     = PH_LEN;
        w_state_nxt = ST_IDLE;
`ifdef AES_GCM_FEED_BACK2BACK_EN
        if (i_desc_valid) begin
          w_desc_acc  = 1'b1;
          w_state_nxt = w_first_state;
        end
`endif
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Descriptor latch, block counters, running counter block and registered beat outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_iv            <= '0;
      r_key           <= '0;
      r_aad_len       <= '0;
      r_pt_len        <= '0;
      r_naad          <= '0;
      r_npt           <= '0;
      r_cb            <= '0;
      r_pending_new   <= 1'b0;
      o_phase         <= '0;
      o_new_instance  <= 1'b0;
      o_j0            <= '0;
      o_cb            <= '0;
      o_aad           <= '0;
      o_plain_text    <= '0;
      o_instance_size <= '0;
      o_key_schedule  <= '0;
    end else begin
      if (w_desc_acc) begin
        r_iv      <= i_iv;
        r_key     <= i_key_schedule;
        r_aad_len <= i_aad_len;
        r_pt_len  <= i_pt_len;
        r_naad    <= w_naad_calc;
        r_npt     <= w_npt_calc;
        r_cb      <= {i_iv, J0_SUFFIX};
      end else if (w_data_acc) begin
        if (w_phase == PH_PT) begin
          r_cb  <= w_cb_inc;
          r_npt <= r_npt - CNT_W'(1);
        end else begin
          r_naad <= r_naad - CNT_W'(1);
        end
      end

      // A LEN beat and a back-to-back accept can coincide: the beat consumes the old
      // flag while the new instance re-arms it.
      if (w_desc_acc)             r_pending_new <= 1'b1;
      else if (w_phase != PH_NONE) r_pending_new <= 1'b0;

      o_phase        <= w_phase;
      o_new_instance <= (w_phase != PH_NONE) && r_pending_new;
      if (w_phase != PH_NONE) begin
        o_j0            <= {r_iv, J0_SUFFIX};
        o_key_schedule  <= r_key;
        o_instance_size <= w_size;
        o_cb            <= (w_phase == PH_PT) ? w_cb_inc : r_cb;
        o_aad           <= (w_phase == PH_AAD) ? i_data : '0;
        o_plain_text    <= (w_phase == PH_PT) ? i_data : '0;
      end
    end
  end

endmodule
